// File: rtl/inst_cache_pkg.sv
// Shared encodings for the instruction cache: bus widths, active levels and
// the controller state type.
package inst_cache_pkg;

  localparam int   INST_ADDR_W = 32;
  localparam int   INST_W      = 32;
  localparam logic RST_ENABLE  = 1'b1;
  localparam logic CHIP_ENABLE = 1'b1;

  typedef enum logic {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction cache data array: one synchronous write port, one combinational
// read port. Contents are not reset; the valid bits in the parent guard them.
module icache_data_ram
  import inst_cache_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_W    = INST_W
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with word-by-word line refill.
//   state         | meaning
//   ICACHE_IDLE   | lookup; hit returns data same cycle, miss latches line and refills
//   ICACHE_REFILL | fetch words cnt=0..last from memory, then mark line valid
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic                   invalidate,
  output logic [INST_W-1:0]      inst,
  output logic                   stallreq,
  output logic                   mem_req,
  output logic [INST_ADDR_W-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic [INST_W-1:0]      mem_rdata
);

  localparam int TAG_BITS = INST_ADDR_W - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic                   unused_pc_bits;

  assign offset = pc[OFFSET_BITS+1:2];
  assign index  = pc[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
  assign tag    = pc[INST_ADDR_W-1:INDEX_BITS+OFFSET_BITS+2];
  assign unused_pc_bits = ^pc[1:0];

  icache_state_e          state, state_nxt;
  logic [LINES-1:0]       valid;
  logic [TAG_BITS-1:0]    tag_ram [LINES];
  logic [TAG_BITS-1:0]    rtag;
  logic [INDEX_BITS-1:0]  rindex;
  logic [OFFSET_BITS-1:0] cnt;
  logic                   cancel;

  logic              fetch_en, hit, miss, word_ack, last_ack;
  logic [INST_W-1:0] rd_data;

  // An invalidate pulse in IDLE forces a miss even if the line looks valid.
  assign fetch_en = (ce == CHIP_ENABLE);
  assign hit      = fetch_en && (state == ICACHE_IDLE) && !invalidate &&
                    valid[index] && (tag_ram[index] == tag);
  assign miss     = fetch_en && (state == ICACHE_IDLE) && !hit;
  assign word_ack = (state == ICACHE_REFILL) && mem_ack;
  assign last_ack = word_ack && (cnt == LAST_WORD);

  icache_data_ram #(
    .ADDR_BITS (INDEX_BITS + OFFSET_BITS),
    .DATA_W    (INST_W)
  ) u_data_ram (
    .clk   (clk),
    .we    (word_ack),
    .waddr ({rindex, cnt}),
    .wdata (mem_rdata),
    .raddr ({index, offset}),
    .rdata (rd_data)
  );

  always_comb begin
    state_nxt = state;
    inst      = '0;
    stallreq  = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    case (state)
      ICACHE_IDLE: begin
        if (hit) inst = rd_data;
        if (miss) begin
          stallreq  = 1'b1;
          state_nxt = ICACHE_REFILL;
        end
      end
      ICACHE_REFILL: begin
        stallreq = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {rtag, rindex, cnt, 2'b00};
        if (last_ack) state_nxt = ICACHE_IDLE;
      end
      default: state_nxt = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state  <= ICACHE_IDLE;
      valid  <= '0;
      cnt    <= '0;
      cancel <= 1'b0;
    end else begin
      state <= state_nxt;
      if (miss) begin
        cnt    <= '0;
        cancel <= 1'b0;
      end
      if (word_ack) cnt <= cnt + 1'b1;
      if (invalidate) begin
        valid <= '0;
        if (state == ICACHE_REFILL) cancel <= 1'b1;
      end
      // A cancelled refill still closes the handshake but leaves the line invalid.
      if (last_ack) begin
        cancel <= 1'b0;
        if (!cancel && !invalidate) valid[rindex] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (miss) begin
      rtag   <= tag;
      rindex <= index;
    end
    if (last_ack) tag_ram[rindex] <= rtag;
  end

endmodule
